// File: rtl/gs_ddram_bridge.sv
// General Sound byte port to 64-bit DDRAM bridge with a one-word read cache.
// Requests start on rd/we rising edges and are served one at a time.
module gs_ddram_bridge #(
  parameter logic [28:0] BASE_WADDR = 29'h0600_0000
) (
  input  logic        DDRAM_CLK,
  input  logic        reset_n,
  input  logic [20:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        we,
  input  logic        rd,
  output logic        ready,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE
);

  typedef enum logic [1:0] {IDLE, WR, RD_CMD, RD_WAIT} state_t;

  state_t      state_reg;
  logic        old_rd_reg;
  logic        old_we_reg;
  logic [20:0] cmd_addr_reg;
  logic [7:0]  cmd_din_reg;
  logic [7:0]  cmd_be_reg;
  logic [63:0] cache_word_reg;
  logic [17:0] cache_tag_reg;
  logic        cache_valid_reg;
  logic [7:0]  dout_reg;
  logic        ready_reg;
  logic        ddr_rd_reg;
  logic        ddr_we_reg;

  logic        write_start;
  logic        read_start;
  logic        cache_hit;
  logic        wt_hit;
  logic [7:0]  hit_byte;
  logic [7:0]  rx_byte;
  logic [63:0] patched_word;

  // Write wins when both strobes rise together.
  assign write_start = we & ~old_we_reg;
  assign read_start  = rd & ~old_rd_reg & ~write_start;
  assign cache_hit   = cache_valid_reg && (cache_tag_reg == addr[20:3]);
  assign wt_hit      = cache_valid_reg && (cache_tag_reg == cmd_addr_reg[20:3]);
  assign hit_byte    = cache_word_reg[{addr[2:0], 3'b000} +: 8];
  assign rx_byte     = DDRAM_DOUT[{cmd_addr_reg[2:0], 3'b000} +: 8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign patched_word[8*gi +: 8] = (cmd_addr_reg[2:0] == 3'(gi)) ?
                                       cmd_din_reg : cache_word_reg[8*gi +: 8];
    end
  endgenerate

  assign dout           = dout_reg;
  assign ready          = ready_reg;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = BASE_WADDR | {11'd0, cmd_addr_reg[20:3]};
  assign DDRAM_DIN      = {8{cmd_din_reg}};
  assign DDRAM_BE       = cmd_be_reg;
  assign DDRAM_RD       = ddr_rd_reg;
  assign DDRAM_WE       = ddr_we_reg;

  always_ff @(posedge DDRAM_CLK) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      old_rd_reg      <= 1'b0;
      old_we_reg      <= 1'b0;
      cmd_addr_reg    <= '0;
      cmd_din_reg     <= '0;
      cmd_be_reg      <= '0;
      cache_word_reg  <= '0;
      cache_tag_reg   <= '0;
      cache_valid_reg <= 1'b0;
      dout_reg        <= 8'hFF;
      ready_reg       <= 1'b1;
      ddr_rd_reg      <= 1'b0;
      ddr_we_reg      <= 1'b0;
    end else begin
      old_rd_reg <= rd;
      old_we_reg <= we;
      case (state_reg)
        IDLE: begin
          if (write_start || read_start) begin
            cmd_addr_reg <= addr;
            cmd_din_reg  <= din;
            cmd_be_reg   <= 8'd1 << addr[2:0];
          end
          if (write_start) begin
            ready_reg  <= 1'b0;
            ddr_we_reg <= 1'b1;
            state_reg  <= WR;
          end else if (read_start) begin
            if (cache_hit) begin
              dout_reg <= hit_byte;
            end else begin
              ready_reg  <= 1'b0;
              ddr_rd_reg <= 1'b1;
              state_reg  <= RD_CMD;
            end
          end
        end
        WR: begin
          if (!DDRAM_BUSY) begin
            ddr_we_reg <= 1'b0;
            ready_reg  <= 1'b1;
            state_reg  <= IDLE;
            // Keep the cached word coherent with the byte just written.
            if (wt_hit) cache_word_reg <= patched_word;
          end
        end
        RD_CMD: begin
          if (!DDRAM_BUSY) begin
            ddr_rd_reg <= 1'b0;
            state_reg  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (DDRAM_DOUT_READY) begin
            cache_word_reg  <= DDRAM_DOUT;
            cache_tag_reg   <= cmd_addr_reg[20:3];
            cache_valid_reg <= 1'b1;
            dout_reg        <= rx_byte;
            ready_reg       <= 1'b1;
            state_reg       <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gs_ddram_bridge.sv
// Testbench for gs_ddram_bridge: DDR word model with fixed-latency read responder
// and a scoreboard of expected read bytes.
module tb_gs_ddram_bridge;

  localparam logic [28:0] BASE_WADDR = 29'h0600_0000;
  localparam logic [63:0] DEFAULT_WORD = 64'h1122_3344_5566_7788;

  logic        DDRAM_CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic [20:0] addr = '0;
  logic [7:0]  din = '0;
  logic [7:0]  dout;
  logic        we = 1'b0;
  logic        rd = 1'b0;
  logic        ready;
  logic        DDRAM_BUSY = 1'b0;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT = '0;
  logic        DDRAM_DOUT_READY = 1'b0;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;

  gs_ddram_bridge #(.BASE_WADDR(BASE_WADDR)) dut (
    .DDRAM_CLK(DDRAM_CLK), .reset_n(reset_n), .addr(addr), .din(din), .dout(dout),
    .we(we), .rd(rd), .ready(ready), .DDRAM_BUSY(DDRAM_BUSY),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DOUT(DDRAM_DOUT),
    .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .DDRAM_RD(DDRAM_RD), .DDRAM_DIN(DDRAM_DIN),
    .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
  );

  always #5 DDRAM_CLK = ~DDRAM_CLK;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_dout = 8'hFF;

  int rd_accepts = 0;
  int rd_hi = 0;
  int we_accepts = 0;
  int we_busy = 0;
  logic [28:0] last_rd_addr = '0;
  logic [28:0] resp_addr = '0;
  int resp_cnt = 0;
  logic [63:0] mem [logic [28:0]];

  function automatic logic [63:0] mem_get(input logic [28:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return DEFAULT_WORD;
  endfunction

  // Bus monitor, DDR word model and read responder (data 3 cycles after accept).
  always @(posedge DDRAM_CLK) begin
    if (reset_n) begin
      if (DDRAM_RD) rd_hi++;
      if (DDRAM_RD && !DDRAM_BUSY) begin
        rd_accepts++;
        last_rd_addr = DDRAM_ADDR;
        resp_addr = DDRAM_ADDR;
        resp_cnt = 3;
      end
      if (DDRAM_WE && DDRAM_BUSY) we_busy++;
      if (DDRAM_WE && !DDRAM_BUSY) begin
        logic [63:0] w;
        we_accepts++;
        w = mem_get(DDRAM_ADDR);
        for (int i = 0; i < 8; i++)
          if (DDRAM_BE[i]) w[8*i +: 8] = DDRAM_DIN[8*i +: 8];
        mem[DDRAM_ADDR] = w;
      end
    end
    #1;
    DDRAM_DOUT_READY = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        DDRAM_DOUT = mem_get(resp_addr);
        DDRAM_DOUT_READY = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge DDRAM_CLK);
    #1;
  endtask

  task automatic do_write(input logic [20:0] a, input logic [7:0] d, input int busy_n,
                          input string name);
    int wb0, wa0, cyc;
    logic [28:0] exp_addr;
    logic [7:0]  exp_be;
    wb0 = we_busy;
    wa0 = we_accepts;
    exp_addr = BASE_WADDR | {11'd0, a[20:3]};
    exp_be = 8'd1 << a[2:0];
    addr = a; din = d; we = 1'b1; DDRAM_BUSY = (busy_n > 0);
    tick();
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL %s ready_low: got %b want 0", name, ready); end
    tests++; if (DDRAM_WE !== 1'b1) begin fails++; $display("FAIL %s we_high: got %b want 1", name, DDRAM_WE); end
    tests++; if (DDRAM_ADDR !== exp_addr) begin fails++; $display("FAIL %s addr: got %h want %h", name, DDRAM_ADDR, exp_addr); end
    tests++; if (DDRAM_BE !== exp_be) begin fails++; $display("FAIL %s be: got %h want %h", name, DDRAM_BE, exp_be); end
    tests++; if (DDRAM_DIN !== {8{d}}) begin fails++; $display("FAIL %s din: got %h want %h", name, DDRAM_DIN, {8{d}}); end
    for (int i = 0; i < busy_n; i++) tick();
    DDRAM_BUSY = 1'b0;
    cyc = 0;
    while (ready !== 1'b1 && cyc < 50) begin tick(); cyc++; end
    tests++; if (cyc !== 1) begin fails++; $display("FAIL %s ready_latency: got %0d want 1", name, cyc); end
    tests++; if (DDRAM_WE !== 1'b0) begin fails++; $display("FAIL %s we_drop: got %b want 0", name, DDRAM_WE); end
    tests++; if (we_busy - wb0 !== busy_n) begin fails++; $display("FAIL %s we_busy_cycles: got %0d want %0d", name, we_busy - wb0, busy_n); end
    tests++; if (we_accepts - wa0 !== 1) begin fails++; $display("FAIL %s we_accepts: got %0d want 1", name, we_accepts - wa0); end
    tests++; if (dout !== exp_dout) begin fails++; $display("FAIL %s dout_hold: got %h want %h", name, dout, exp_dout); end
    $display("[TB] write %s addr=%h din=%h busy=%0d", name, a, d, busy_n);
    we = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [20:0] a, input bit expect_miss, input bit keep_rd,
                         input string name);
    int rd0, hi0, cyc;
    logic [63:0] w;
    logic [7:0] exp_b;
    logic [28:0] exp_addr;
    exp_addr = BASE_WADDR | {11'd0, a[20:3]};
    w = mem_get(exp_addr);
    exp_q.push_back(w[{a[2:0], 3'b000} +: 8]);
    rd0 = rd_accepts;
    hi0 = rd_hi;
    addr = a; rd = 1'b1;
    tick();
    tests++;
    if (ready !== (expect_miss ? 1'b0 : 1'b1)) begin
      fails++; $display("FAIL %s ready_after_start: got %b want %b", name, ready, !expect_miss);
    end
    cyc = 0;
    while (ready !== 1'b1 && cyc < 50) begin tick(); cyc++; end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL %s ready_timeout: got %b want 1", name, ready); end
    exp_b = exp_q.pop_front();
    exp_dout = exp_b;
    tests++; if (dout !== exp_b) begin fails++; $display("FAIL %s dout: got %h want %h", name, dout, exp_b); end
    tests++;
    if (rd_accepts - rd0 !== (expect_miss ? 1 : 0)) begin
      fails++; $display("FAIL %s rd_cmds: got %0d want %0d", name, rd_accepts - rd0, expect_miss ? 1 : 0);
    end
    if (expect_miss) begin
      tests++; if (last_rd_addr !== exp_addr) begin fails++; $display("FAIL %s rd_addr: got %h want %h", name, last_rd_addr, exp_addr); end
      tests++; if (rd_hi - hi0 !== 1) begin fails++; $display("FAIL %s rd_width: got %0d want 1", name, rd_hi - hi0); end
    end
    $display("[TB] read %s addr=%h dout=%h miss=%0d", name, a, dout, expect_miss);
    if (!keep_rd) begin
      rd = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rd = 1'b0; we = 1'b0; DDRAM_BUSY = 1'b0;
    tick(); tick();
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset ready: got %b want 1", ready); end
    tests++; if (dout !== 8'hFF) begin fails++; $display("FAIL reset dout: got %h want ff", dout); end
    tests++; if (DDRAM_RD !== 1'b0) begin fails++; $display("FAIL reset rd: got %b want 0", DDRAM_RD); end
    tests++; if (DDRAM_WE !== 1'b0) begin fails++; $display("FAIL reset we: got %b want 0", DDRAM_WE); end
    tests++; if (DDRAM_BURSTCNT !== 8'd1) begin fails++; $display("FAIL reset burstcnt: got %h want 01", DDRAM_BURSTCNT); end
    exp_dout = 8'hFF;
    $display("[TB] reset ready=%b dout=%h", ready, dout);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    do_write(21'h00005, 8'hA5, 3, "write_busy3");
  endtask

  task automatic test_read_miss();
    do_read(21'h1FFFF9, 1'b1, 1'b0, "read_miss");
    tests++; if (exp_dout !== 8'h77 || dout !== 8'h77) begin fails++; $display("FAIL read_miss_value: got %h want 77", dout); end
  endtask

  task automatic test_read_hit();
    do_read(21'h1FFFFE, 1'b0, 1'b0, "read_hit");
    tests++; if (dout !== 8'h22) begin fails++; $display("FAIL read_hit_value: got %h want 22", dout); end
  endtask

  task automatic test_write_through();
    do_write(21'h1FFFF8, 8'h5A, 0, "write_through");
    do_read(21'h1FFFF8, 1'b0, 1'b0, "hit_after_write");
    tests++; if (dout !== 8'h5A) begin fails++; $display("FAIL write_through_value: got %h want 5a", dout); end
  endtask

  task automatic test_simultaneous();
    int rd0, wa0, cyc;
    rd0 = rd_accepts;
    wa0 = we_accepts;
    addr = 21'h00010; din = 8'h3C; we = 1'b1; rd = 1'b1; DDRAM_BUSY = 1'b0;
    tick();
    cyc = 0;
    while (ready !== 1'b1 && cyc < 50) begin tick(); cyc++; end
    tests++; if (we_accepts - wa0 !== 1) begin fails++; $display("FAIL simul_write: got %0d want 1", we_accepts - wa0); end
    we = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    tests++; if (rd_accepts - rd0 !== 0) begin fails++; $display("FAIL simul_no_read: got %0d want 0", rd_accepts - rd0); end
    tests++; if (dout !== exp_dout) begin fails++; $display("FAIL simul_dout_hold: got %h want %h", dout, exp_dout); end
    $display("[TB] simultaneous rd/we writes=%0d reads=%0d", we_accepts - wa0, rd_accepts - rd0);
    rd = 1'b0;
    tick();
    // A level held after a completed read must not issue another command.
    do_read(21'h00018, 1'b1, 1'b1, "miss_then_hold");
    rd0 = rd_accepts;
    for (int i = 0; i < 8; i++) tick();
    tests++; if (rd_accepts - rd0 !== 0) begin fails++; $display("FAIL hold_rd_retrigger: got %0d want 0", rd_accepts - rd0); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL hold_rd_ready: got %b want 1", ready); end
    $display("[TB] hold rd extra_reads=%0d", rd_accepts - rd0);
    rd = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    int rd0;
    rd0 = rd_accepts;
    addr = 21'h00020; rd = 1'b1;
    tick();
    tick();
    tests++; if (rd_accepts - rd0 !== 1) begin fails++; $display("FAIL midrst_cmd: got %0d want 1", rd_accepts - rd0); end
    reset_n = 1'b0; rd = 1'b0;
    tick();
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b want 1", ready); end
    tests++; if (dout !== 8'hFF) begin fails++; $display("FAIL midrst_dout: got %h want ff", dout); end
    tests++; if (DDRAM_RD !== 1'b0 || DDRAM_WE !== 1'b0) begin fails++; $display("FAIL midrst_cmds: got rd=%b we=%b want 0 0", DDRAM_RD, DDRAM_WE); end
    exp_dout = 8'hFF;
    reset_n = 1'b1;
    tick(); tick(); tick();
    tests++; if (dout !== 8'hFF) begin fails++; $display("FAIL stale_dout_ready: got %h want ff", dout); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL stale_ready: got %b want 1", ready); end
    $display("[TB] reset mid-read dout=%h ready=%b", dout, ready);
    // Cache must be invalid after reset.
    do_read(21'h1FFFFE, 1'b1, 1'b0, "miss_after_reset");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_miss();
    test_read_hit();
    test_write_through();
    test_simultaneous();
    test_reset_mid_op();
    tests++; if (exp_q.size() !== 0) begin fails++; $display("FAIL scoreboard_empty: got %0d want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
